// File: rtl/srt_result_reader.sv
// Read-back engine for the sorted array in dm: streams elements 1..N over valid/ready
// and reports descent count, first offending index and elapsed scan cycles.
module srt_result_reader #(
  parameter int AW = 9,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          sorted_ok,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] first_err_idx,
  output logic [CW-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDN  = 3'd1,
    S_RD   = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t        r_state;
  logic [AW-1:0] r_n;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_prev;
  logic [AW-1:0] r_mem_addr;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_index;
  logic          r_out_last;
  logic          r_busy;
  logic          r_done;
  logic          r_sorted_ok;
  logic [CW-1:0] r_err_cnt;
  logic [AW-1:0] r_first_err_idx;
  logic [CW-1:0] r_cycles;

  logic [AW-1:0] w_n;
  logic          w_desc;
  logic          w_at_last;

  // Element count from word 0, clamped to the largest addressable index.
  always_comb begin
    w_n = mem_rdata[AW-1:0];
    if (|mem_rdata[DW-1:AW]) begin
      w_n = {AW{1'b1}};
    end else begin
      w_n = mem_rdata[AW-1:0];
    end
  end

  assign w_desc    = (r_idx > IDX_ONE) && (mem_rdata < r_prev);
  assign w_at_last = (r_idx == r_n);

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state         <= S_IDLE;
      r_n             <= {AW{1'b0}};
      r_idx           <= {AW{1'b0}};
      r_prev          <= {DW{1'b0}};
      r_mem_addr      <= {AW{1'b0}};
      r_out_valid     <= 1'b0;
      r_out_data      <= {DW{1'b0}};
      r_out_index     <= {AW{1'b0}};
      r_out_last      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_sorted_ok     <= 1'b0;
      r_err_cnt       <= {CW{1'b0}};
      r_first_err_idx <= {AW{1'b0}};
      r_cycles        <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_LDN;
            r_mem_addr      <= {AW{1'b0}};
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_sorted_ok     <= 1'b0;
            r_err_cnt       <= {CW{1'b0}};
            r_first_err_idx <= {AW{1'b0}};
            r_cycles        <= {CW{1'b0}};
            r_out_data      <= {DW{1'b0}};
            r_out_index     <= {AW{1'b0}};
          end else begin
            r_state <= r_state;
          end
        end
        S_LDN: begin
          r_cycles <= sat_inc(r_cycles);
          r_n      <= w_n;
          if (w_n == {AW{1'b0}}) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_sorted_ok <= (r_err_cnt == {CW{1'b0}});
            r_mem_addr  <= {AW{1'b0}};
          end else begin
            r_state    <= S_RD;
            r_idx      <= IDX_ONE;
            r_mem_addr <= IDX_ONE;
          end
        end
        S_RD: begin
          r_cycles    <= sat_inc(r_cycles);
          r_out_data  <= mem_rdata;
          r_out_index <= r_idx;
          r_prev      <= mem_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= w_at_last;
          r_state     <= S_OUT;
          if (w_desc) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            // Only the first descent of a scan records its index.
            if (r_err_cnt == {CW{1'b0}}) begin
              r_first_err_idx <= r_idx;
            end else begin
              r_first_err_idx <= r_first_err_idx;
            end
          end else begin
            r_err_cnt <= r_err_cnt;
          end
        end
        S_OUT: begin
          r_cycles <= sat_inc(r_cycles);
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_at_last) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_sorted_ok <= (r_err_cnt == {CW{1'b0}});
              r_mem_addr  <= {AW{1'b0}};
            end else begin
              r_state    <= S_RD;
              r_idx      <= r_idx + IDX_ONE;
              r_mem_addr <= r_idx + IDX_ONE;
            end
          end else begin
            r_state <= S_OUT;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_out_valid <= 1'b0;
          r_mem_addr  <= {AW{1'b0}};
        end
      endcase
    end
  end

  assign mem_addr      = r_mem_addr;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_index     = r_out_index;
  assign out_last      = r_out_last;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sorted_ok     = r_sorted_ok;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_err_idx;
  assign cycles        = r_cycles;

endmodule

// File: tb/tb_srt_result_reader.sv
// Directed bench for srt_result_reader: a bench-owned dm model feeds the async read port,
// beats are collected at the falling edge and compared with the hand-built memory image.
module tb_srt_result_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [8:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        sorted_ok;
  logic [15:0] err_cnt;
  logic [8:0]  first_err_idx;
  logic [15:0] cycles;

  logic [31:0] mem [512];
  assign mem_rdata = mem[mem_addr];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q_d[$];
  int          q_i[$];
  logic        q_l[$];
  int          first_valid_iter;

  always #5 clk = ~clk;

  srt_result_reader #(.AW(9), .DW(32), .CW(16)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .sorted_ok(sorted_ok),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .cycles(cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then services the stream until done, an optional reset abort, or the cycle budget.
  task automatic scan(input int bp_idx, input int st_idx, input int rst_idx);
    int held = 0;
    int guard = 0;
    bit st_sent = 1'b0;
    bit aborted = 1'b0;
    q_d.delete(); q_i.delete(); q_l.delete();
    first_valid_iter = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (done !== 1'b1 && guard < 3000) begin
      start = 1'b0;
      if (out_valid && first_valid_iter < 0) first_valid_iter = guard;
      if (rst_idx != 0 && out_valid && int'(out_index) == rst_idx) begin
        rstn = 1'b1;
        #1;
        chk("rst_outs", 64'({out_valid, out_last, busy, done, sorted_ok, mem_addr, out_index,
                              first_err_idx, err_cnt, cycles}), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        @(negedge clk); rstn = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (st_idx != 0 && out_valid && int'(out_index) == st_idx && !st_sent) begin
        start = 1'b1;
        st_sent = 1'b1;
      end
      if (bp_idx != 0 && out_valid && int'(out_index) == bp_idx && held < 3) begin
        out_ready = 1'b0;
        held++;
        chk("bp_data_hold", 64'(out_data), 64'(mem[bp_idx]));
        chk("bp_index_hold", 64'(out_index), 64'(bp_idx));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        q_d.push_back(out_data);
        q_i.push_back(int'(out_index));
        q_l.push_back(out_last);
      end
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!aborted) chk("scan_timeout", 64'(guard < 3000), 64'd1);
  endtask

  // Compares collected beats against mem[1..n] in address order.
  task automatic check_stream(input string tag, input int n);
    int bad = 0;
    chk({tag, "_beats"}, 64'(q_d.size()), 64'(n));
    for (int k = 0; k < q_d.size() && k < n; k++) begin
      if (q_i[k] != k + 1) bad++;
      if (q_d[k] !== mem[k+1]) bad++;
      if (q_l[k] !== (k + 1 == n)) bad++;
    end
    chk({tag, "_content"}, 64'(bad), 64'd0);
  endtask

  task automatic check_result(input string tag, input logic ok, input int errs, input int fidx,
                              input int cyc);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sorted_ok"}, 64'(sorted_ok), 64'(ok));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(errs));
    chk({tag, "_first_err"}, 64'(first_err_idx), 64'(fidx));
    chk({tag, "_cycles"}, 64'(cycles), 64'(cyc));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({out_valid, busy, done, sorted_ok, mem_addr, err_cnt, cycles}), 64'd0);
    rstn = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({out_valid, busy, done}), 64'd0);

    // 1: sorted data
    mem[0] = 32'd4; mem[1] = 32'd3; mem[2] = 32'd7; mem[3] = 32'd7; mem[4] = 32'd20;
    scan(0, 0, 0);
    chk("t1_latency", 64'(first_valid_iter), 64'd2);
    chk("t1_beat2_data", 64'(q_d.size() > 1 ? q_d[1] : 32'hDEAD), 64'd7);
    check_stream("t1", 4);
    check_result("t1", 1'b1, 0, 0, 9);

    // 2: unsorted data, descents at 3 and 5
    mem[0] = 32'd5; mem[1] = 32'd1; mem[2] = 32'd9; mem[3] = 32'd4; mem[4] = 32'd8; mem[5] = 32'd2;
    scan(0, 0, 0);
    check_stream("t2", 5);
    check_result("t2", 1'b0, 2, 3, 11);

    // 3a: comparison must be unsigned
    mem[0] = 32'd2; mem[1] = 32'h7FFF_FFFF; mem[2] = 32'h8000_0000;
    scan(0, 0, 0);
    check_stream("t3a", 2);
    check_result("t3a", 1'b1, 0, 0, 5);

    // 3b: empty array
    mem[0] = 32'd0;
    scan(0, 0, 0);
    chk("t3b_beats", 64'(q_d.size()), 64'd0);
    check_result("t3b", 1'b1, 0, 0, 1);

    // 4: backpressure on beat 2
    mem[0] = 32'd4; mem[1] = 32'd3; mem[2] = 32'd7; mem[3] = 32'd7; mem[4] = 32'd20;
    scan(2, 0, 0);
    check_stream("t4", 4);
    check_result("t4", 1'b1, 0, 0, 12);

    // 5: start during beat 2 is ignored
    scan(0, 2, 0);
    check_stream("t5a", 4);
    check_result("t5a", 1'b1, 0, 0, 9);

    // 5: reset during beat 3 aborts, then a clean replay
    scan(0, 0, 3);
    chk("t5b_beats_before_rst", 64'(q_d.size()), 64'd2);
    repeat (3) @(negedge clk);
    chk("t5b_idle_after_rst", 64'({out_valid, busy, done}), 64'd0);
    scan(0, 0, 0);
    check_stream("t5c", 4);
    check_result("t5c", 1'b1, 0, 0, 9);

    // 6: count clamp to 511
    mem[0] = 32'h0000_0300;
    for (int i = 1; i < 512; i++) mem[i] = 32'(i * 3);
    scan(0, 0, 0);
    check_stream("t6", 511);
    chk("t6_last_index", 64'(q_i.size() > 0 ? q_i[q_i.size()-1] : 0), 64'd511);
    check_result("t6", 1'b1, 0, 0, 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/srt_result_reader.md
Name: srt_result_reader

Overview:
- Read-back engine for the sort array in the shared dm memory, after the sort engine asserts done.
- Memory layout: word 0 holds count N; elements sit at addresses 1..N.
- Scans elements in address order and streams each one out over a valid/ready handshake.
- Checks non-decreasing (unsigned) order and reports error count, first offending index and elapsed cycles, so the board, SDU or bench can confirm the sort without a debugger dump.

Parameters:
AW, 9, memory address width (dm depth 512 words)
DW, 32, memory data width
CW, 16, width of cycle and error counters

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-high
start  input  1  single-cycle start pulse (already edge-detected upstream); ignored unless idle or done
mem_addr  output  AW  read address to dm async-read port
mem_rdata  input  DW  dm read data, combinational from mem_addr in the same cycle
out_valid  output  1  element beat valid
out_ready  input  1  sink accepts beat
out_data  output  DW  element value
out_index  output  AW  element address (1..N)
out_last  output  1  high on the beat of element N
busy  output  1  scan in progress
done  output  1  scan complete; results held
sorted_ok  output  1  err_cnt==0; meaningful only when done=1
err_cnt  output  CW  count of descents, saturating
first_err_idx  output  AW  index of first element smaller than its predecessor; 0 if none
cycles  output  CW  cycles from start acceptance to DONE entry, saturating

Behaviour:
- Reset: all outputs, including mem_addr, and all internal registers go to 0; FSM enters IDLE. Reset mid-scan aborts immediately; no further beats are issued.
- States: IDLE, LDN, RD, OUT, DONE.
- IDLE:
  - mem_addr=0.
  - start -> LDN.
  - Start acceptance (IDLE or DONE) clears err_cnt, first_err_idx, cycles, out_data and out_index.
- LDN:
  - mem_addr=0; latch N from mem_rdata.
  - If mem_rdata[DW-1:AW]!=0, N is clamped to 2^AW-1.
  - N==0 -> DONE; otherwise idx<=1 -> RD.
- RD:
  - mem_addr=idx.
  - out_data<=mem_rdata; out_index<=idx.
  - If idx>1 and mem_rdata<prev (unsigned): err_cnt increments (saturating at 2^CW-1); if err_cnt was 0, first_err_idx<=idx.
  - prev<=mem_rdata.
  - Next state OUT.
- OUT:
  - out_valid=1.
  - out_data and out_index are stable while out_ready=0; the beat is held indefinitely with no timeout.
  - out_last = (idx==N).
  - On out_valid&&out_ready: if idx==N -> DONE; else idx<=idx+1 -> RD.
- DONE:
  - done=1; sorted_ok=(err_cnt==0); results held.
  - start -> LDN, restarting the scan with cleared results.
- Output flags:
  - busy=1 in LDN/RD/OUT.
  - mem_addr is driven 0 in IDLE and DONE.
- Cycle counter:
  - cycles increments in every LDN/RD/OUT cycle, saturating at 2^CW-1.
  - With out_ready held high, total = 1+2N.
- Start rules:
  - start during busy is ignored, with no state or result change.
  - start and the final handshake in the same cycle: the handshake wins (-> DONE); start is dropped.
- Memory access:
  - Read-only; the block never writes dm.
  - Memory-port ownership versus the sort engine and SDU is arbitrated outside this block.
- Latency: first beat valid 2 cycles after start acceptance; minimum 2 cycles per element.

Test Plan:
1. Sorted data: mem[0]=4, mem[1..4]=3,7,7,20, out_ready=1, start pulse -> beats (1,3),(2,7),(3,7),(4,20); out_last only on beat 4; done=1, sorted_ok=1, err_cnt=0, first_err_idx=0, cycles=9.
2. Unsorted data: mem[0]=5, mem[1..5]=1,9,4,8,2 -> 5 beats in address order; err_cnt=2, first_err_idx=3, sorted_ok=0, cycles=11.
3. Unsigned compare and empty array:
   - mem[1..2]=0x7FFFFFFF,0x80000000 with N=2 -> err_cnt=0.
   - N=0 -> no beats; done=1, sorted_ok=1, cycles=1.
4. Backpressure: case 1 with out_ready=0 for 3 cycles while beat 2 is valid -> out_data=7 and out_index=2 held stable, no beat lost or duplicated; cycles=12.
5. Mid-scan start and reset:
   - start pulse during beat 2 -> ignored; stream completes unchanged.
   - rstn pulse during beat 3 -> all outputs 0 and IDLE immediately.
   - A subsequent start replays the full stream with correct results.
6. N clamp: mem[0]=0x00000300, out_ready=1 -> 511 beats, indices 1..511; out_last on index 511; cycles=1023.
